// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute control unit for an accumulator datapath.
// Optional macro CU_JMP_EN: opcode 10 becomes a jump; when it is undefined, opcode 10 is a NOP.
module control_unit #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [N-3:0] mem_addr,
  output logic         mem_rd,
  output logic         ALUSEL,
  output logic         AR_LD,
  output logic         AC_LD,
  output logic         busy,
  output logic         halted
);

  localparam int unsigned AW = N - 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StOperand,
    StExec,
    StHalted
  } state_e;

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpAnd  = 2'b01;
  localparam logic [1:0] OpJmp  = 2'b10;
  localparam logic [1:0] OpHalt = 2'b11;

  state_e        r_state;
  logic [AW-1:0] r_pc;
  logic [N-1:0]  r_ir;

  logic [AW-1:0] r_mem_addr;
  logic          r_mem_rd;
  logic          r_alusel;
  logic          r_ac_ld;
  logic          r_busy;
  logic          r_halted;

  state_e        w_state_d;
  logic [AW-1:0] w_pc_d;
  logic [N-1:0]  w_ir_d;
  logic [1:0]    w_opcode;

  assign w_opcode = r_ir[N-1:N-2];

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_ir_d    = r_ir;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) begin
          w_ir_d    = mem_rdata;
          w_pc_d    = r_pc + AW'(1);
          w_state_d = StDecode;
        end
      end
      StDecode: begin
        unique case (w_opcode)
          OpAdd, OpAnd: w_state_d = StOperand;
          OpHalt:       w_state_d = StHalted;
          OpJmp: begin
`ifdef CU_JMP_EN
            w_pc_d = r_ir[AW-1:0];
`endif
            w_state_d = StFetch;
          end
          default:      w_state_d = StIdle;
        endcase
      end
      StOperand: begin
        if (mem_ready) w_state_d = StExec;
      end
      StExec:   w_state_d = StFetch;
      StHalted: w_state_d = StHalted;
      default:  w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_ir       <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_alusel   <= 1'b0;
      r_ac_ld    <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_ir     <= w_ir_d;
      r_mem_rd <= (w_state_d == StFetch) || (w_state_d == StOperand);
      if (w_state_d == StFetch) begin
        r_mem_addr <= w_pc_d;
      end else if (w_state_d == StOperand) begin
        r_mem_addr <= w_ir_d[AW-1:0];
      end else begin
        r_mem_addr <= '0;
      end
      r_alusel <= ((w_state_d == StOperand) || (w_state_d == StExec)) && w_ir_d[N-2];
      r_ac_ld  <= (w_state_d == StExec);
      r_busy   <= (w_state_d != StIdle) && (w_state_d != StHalted);
      r_halted <= (w_state_d == StHalted);
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_rd   = r_mem_rd;
  assign ALUSEL   = r_alusel;
  assign AC_LD    = r_ac_ld;
  assign busy     = r_busy;
  assign halted   = r_halted;
  // Operand capture happens in the same cycle memory answers.
  assign AR_LD    = (r_state == StOperand) && mem_ready;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model expands each program into an expected
// per-cycle trace of memory handshake and control outputs, driven with random waits and noise.
module tb_control_unit;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [5:0] mem_addr;
  logic       mem_rd;
  logic       ALUSEL;
  logic       AR_LD;
  logic       AC_LD;
  logic       busy;
  logic       halted;

  always #5 clk = ~clk;

  control_unit #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .ALUSEL   (ALUSEL),
    .AR_LD    (AR_LD),
    .AC_LD    (AC_LD),
    .busy     (busy),
    .halted   (halted)
  );

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       rdy;
    logic [7:0] rdata;
    logic       rd;
    logic [5:0] addr;
    logic       ar;
    logic       ac;
    logic       alu;
    logic       bsy;
    logic       hlt;
  } cyc_t;

  cyc_t       q[$];
  logic [7:0] mem[64];
  int         total  = 0;
  int         passed = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Occasional stray start pulse; must be ignored outside IDLE.
  function automatic bit nz();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic add(input bit rd, input logic [5:0] a, input bit rdy, input bit ar,
                     input bit ac, input bit alu, input bit bsy, input bit hlt, input bit strt);
    cyc_t c;
    c.rst   = 1'b0;
    c.start = strt;
    c.rdy   = rdy;
    c.rdata = rd ? mem[a] : 8'($urandom);
    c.rd    = rd;
    c.addr  = rd ? a : 6'd0;
    c.ar    = ar;
    c.ac    = ac;
    c.alu   = alu;
    c.bsy   = bsy;
    c.hlt   = hlt;
    q.push_back(c);
  endtask

  // wm: wait cycles per read (-1 random 0..2); cut: -1 reset at end, -2 random, else index.
  task automatic build(input int wm, input int cap, input int cut);
    cyc_t       c;
    logic [5:0] pc;
    logic [7:0] ir;
    bit         done;
    int         w;
    int         k;
    q.delete();
    pc   = 6'd0;
    done = 1'b0;
    repeat ((wm < 0) ? $urandom_range(1, 2) : 1) add(0, 6'd0, rb(), 0, 0, 0, 0, 0, 0);
    add(0, 6'd0, rb(), 0, 0, 0, 0, 0, 1);
    while (!done && q.size() < cap) begin
      w = (wm < 0) ? $urandom_range(0, 2) : wm;
      repeat (w) add(1, pc, 0, 0, 0, 0, 1, 0, nz());
      add(1, pc, 1, 0, 0, 0, 1, 0, nz());
      ir = mem[pc];
      pc = pc + 6'd1;
      add(0, 6'd0, rb(), 0, 0, 0, 1, 0, nz());
      case (ir[7:6])
        2'b11: begin
          repeat (3) add(0, 6'd0, rb(), 0, 0, 0, 0, 1, nz());
          done = 1'b1;
        end
        2'b10: begin
`ifdef CU_JMP_EN
          pc = ir[5:0];
`endif
        end
        default: begin
          w = (wm < 0) ? $urandom_range(0, 2) : wm;
          repeat (w) add(1, ir[5:0], 0, 0, 0, ir[6], 1, 0, nz());
          add(1, ir[5:0], 1, 1, 0, ir[6], 1, 0, nz());
          add(0, 6'd0, rb(), 0, 1, ir[6], 1, 0, nz());
        end
      endcase
    end
    if (cut == -2) k = $urandom_range(2, q.size() - 1);
    else if (cut >= 0) k = cut;
    else k = q.size() - 1;
    while (q.size() > k + 1) void'(q.pop_back());
    c = q.pop_back();
    c.rst = 1'b1;
    q.push_back(c);
  endtask

  task automatic run(input string name);
    foreach (q[i]) begin
      @(negedge clk);
      rst       = q[i].rst;
      start     = q[i].start;
      mem_ready = q[i].rdy;
      mem_rdata = q[i].rdata;
      #1;
      chk($sformatf("%s[%0d].mem_rd", name, i), {7'd0, mem_rd}, {7'd0, q[i].rd});
      chk($sformatf("%s[%0d].mem_addr", name, i), {2'd0, mem_addr}, {2'd0, q[i].addr});
      chk($sformatf("%s[%0d].AR_LD", name, i), {7'd0, AR_LD}, {7'd0, q[i].ar});
      chk($sformatf("%s[%0d].AC_LD", name, i), {7'd0, AC_LD}, {7'd0, q[i].ac});
      chk($sformatf("%s[%0d].ALUSEL", name, i), {7'd0, ALUSEL}, {7'd0, q[i].alu});
      chk($sformatf("%s[%0d].busy", name, i), {7'd0, busy}, {7'd0, q[i].bsy});
      chk($sformatf("%s[%0d].halted", name, i), {7'd0, halted}, {7'd0, q[i].hlt});
    end
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("reset.mem_rd", {7'd0, mem_rd}, 8'd0);
    chk("reset.mem_addr", {2'd0, mem_addr}, 8'd0);
    chk("reset.AR_LD", {7'd0, AR_LD}, 8'd0);
    chk("reset.AC_LD", {7'd0, AC_LD}, 8'd0);
    chk("reset.ALUSEL", {7'd0, ALUSEL}, 8'd0);
    chk("reset.busy", {7'd0, busy}, 8'd0);
    chk("reset.halted", {7'd0, halted}, 8'd0);

    // ADD from addr 5, then HALT, no waits
    clear_mem();
    mem[0] = 8'h05; mem[5] = 8'h1E; mem[1] = 8'hC0;
    build(0, 100, -1);
    run("add_halt");

    // AND with two wait cycles on every read
    clear_mem();
    mem[0] = 8'h45; mem[1] = 8'hC0;
    build(2, 100, -1);
    run("and_wait");

    // JMP to 10 (taken) or NOP falling through to 1
    clear_mem();
    mem[0] = 8'h8A; mem[10] = 8'hC0; mem[1] = 8'hC0;
    build(0, 100, -1);
    run("jmp");

    // Reach PC=63 (by jump or by NOPs), then the fetch after must wrap to 0
    clear_mem();
    for (int i = 1; i < 63; i++) mem[i] = 8'h80;
    mem[0] = 8'hBF; mem[63] = 8'h00;
    build(0, 200, -1);
    run("wrap");

    // Reset in the first OPERAND wait cycle
    clear_mem();
    mem[0] = 8'h05;
    build(2, 100, 6);
    run("rst_operand");

    for (int t = 0; t < 30; t++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      build(-1, 120, -2);
      run($sformatf("rand%0d", t));
    end

    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("final.busy", {7'd0, busy}, 8'd0);
    chk("final.mem_rd", {7'd0, mem_rd}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
